// File: rtl/rr_mux_arbiter_4_if.sv
// Channel bundle for rr_mux_arbiter_4: four requester valid/ready/data channels,
// the single registered output channel and the accepted-beat counter.
interface rr_mux_arbiter_4_if #(parameter int W = 4);
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0;
    logic [W-1:0] in_data1;
    logic [W-1:0] in_data2;
    logic [W-1:0] in_data3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [7:0]   xfer_cnt;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_src, xfer_cnt
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_src, xfer_cnt
    );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter sharing one 4:1 data mux between four valid/ready requesters,
// feeding a single registered valid/ready output stage.
module rr_mux_arbiter_4 (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_4_if.slave bus
);
    localparam int W = $bits(bus.out_data);

    logic [1:0]   last_grant;
    logic [1:0]   winner;
    logic [1:0]   cand;
    logic         found;
    logic         space;
    logic         accept;
    logic [W-1:0] mux_data;

    // Search starts one past the last grant; offset 4 wraps back to last_grant itself.
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && bus.in_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held.
    always_comb begin
        space        = !bus.out_valid || bus.out_ready;
        accept       = rst_n && space && found;
        bus.in_ready = accept ? (4'b0001 << winner) : 4'b0000;
    end

    always_comb begin
        mux_data = bus.in_data0;
        case (winner)
            2'd0:    mux_data = bus.in_data0;
            2'd1:    mux_data = bus.in_data1;
            2'd2:    mux_data = bus.in_data2;
            default: mux_data = bus.in_data3;
        endcase
    end

    // A load takes priority over a drain so a simultaneous drain+load leaves no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= 2'd0;
            bus.xfer_cnt  <= 8'd0;
            last_grant    <= 2'd3;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= mux_data;
            bus.out_src   <= winner;
            bus.xfer_cnt  <= bus.xfer_cnt + 8'd1;
            last_grant    <= winner;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: vector table, directed corner sequences
// and a randomised run checked against a per-beat expectation queue.
module tb_rr_mux_arbiter_4;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_mux_arbiter_4_if #(.W(4)) bus ();

    rr_mux_arbiter_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       rdy;
        logic [3:0] exp_irdy;
        logic       exp_ov;
        logic [3:0] exp_data;
        logic [1:0] exp_src;
        logic [7:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [1:0] src;
        logic [3:0] data;
    } beat_t;

    vec_t  vecs [11];
    beat_t exp_q [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] vld, input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [3:0] d2, input logic [3:0] d3, input logic rdy);
        @(negedge clk);
        bus.in_valid  = vld;
        bus.in_data0  = d0;
        bus.in_data1  = d1;
        bus.in_data2  = d2;
        bus.in_data3  = d3;
        bus.out_ready = rdy;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkBeat(input string tag, input logic ov, input logic [3:0] data,
                             input logic [1:0] src, input logic [7:0] cnt);
        checkOutput({tag, "_out_valid"}, int'(bus.out_valid), int'(ov));
        checkOutput({tag, "_out_data"},  int'(bus.out_data),  int'(data));
        checkOutput({tag, "_out_src"},   int'(bus.out_src),   int'(src));
        checkOutput({tag, "_xfer_cnt"},  int'(bus.xfer_cnt),  int'(cnt));
    endtask

    logic [3:0] vld;
    logic [3:0] pd [4];
    logic [1:0] mlg;
    logic [1:0] win;
    logic [1:0] c;
    logic       mov;
    logic       acc;
    logic       fnd;
    logic       sp;
    logic       tail;
    logic [7:0] mcnt;
    beat_t      b;

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_data0  = 4'd0;
        bus.in_data1  = 4'd0;
        bus.in_data2  = 4'd0;
        bus.in_data3  = 4'd0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].vld      = 4'b1111;
            vecs[i].d0       = 4'd1;
            vecs[i].d1       = 4'd2;
            vecs[i].d2       = 4'd3;
            vecs[i].d3       = 4'd4;
            vecs[i].rdy      = 1'b1;
            vecs[i].exp_irdy = 4'b0001 << (i % 4);
            vecs[i].exp_ov   = 1'b1;
            vecs[i].exp_data = 4'((i % 4) + 1);
            vecs[i].exp_src  = 2'(i % 4);
            vecs[i].exp_cnt  = 8'(i + 1);
        end
        for (int i = 8; i < 11; i++) begin
            vecs[i].vld      = 4'b0100;
            vecs[i].d0       = 4'd0;
            vecs[i].d1       = 4'd0;
            vecs[i].d2       = 4'hA;
            vecs[i].d3       = 4'd0;
            vecs[i].rdy      = 1'b1;
            vecs[i].exp_irdy = 4'b0100;
            vecs[i].exp_ov   = 1'b1;
            vecs[i].exp_data = 4'hA;
            vecs[i].exp_src  = 2'd2;
            vecs[i].exp_cnt  = 8'(i + 1);
        end

        // Reset state, with requests pending to confirm in_ready stays low.
        #12;
        checkBeat("reset", 1'b0, 4'd0, 2'd0, 8'd0);
        checkOutput("reset_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.in_valid = 4'b0000;
        rst_n        = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].rdy);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(vecs[i].exp_irdy));
            @(posedge clk);
            #1;
            checkBeat($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_src, vecs[i].exp_cnt);
        end

        // Backpressure: hold a beat from source 1, then release.
        applyStimulus(4'b0010, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1);
        #1;
        checkOutput("bp_load_in_ready", int'(bus.in_ready), 4'b0010);
        @(posedge clk);
        #1;
        checkBeat("bp_load", 1'b1, 4'd5, 2'd1, 8'd12);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1111, 4'd1, 4'd5, 4'd3, 4'd4, 1'b0);
            #1;
            checkOutput($sformatf("bp_stall%0d_in_ready", i), int'(bus.in_ready), 0);
            @(posedge clk);
            #1;
            checkBeat($sformatf("bp_stall%0d", i), 1'b1, 4'd5, 2'd1, 8'd12);
        end
        applyStimulus(4'b1111, 4'd1, 4'd5, 4'd3, 4'd4, 1'b1);
        #1;
        checkOutput("bp_release_in_ready", int'(bus.in_ready), 4'b0100);
        @(posedge clk);
        #1;
        checkBeat("bp_release", 1'b1, 4'd3, 2'd2, 8'd13);

        // Drain with no requests: valid falls, stale data and count hold.
        applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        #1;
        checkOutput("drain_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        checkBeat("drain", 1'b0, 4'd3, 2'd2, 8'd13);

        // Reset mid-transfer with last_grant = 1.
        applyStimulus(4'b0010, 4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
        #1;
        checkOutput("midrst_load_in_ready", int'(bus.in_ready), 4'b0010);
        @(posedge clk);
        #1;
        checkBeat("midrst_load", 1'b1, 4'd7, 2'd1, 8'd14);
        applyStimulus(4'b0000, 4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkBeat("midrst_async", 1'b0, 4'd0, 2'd0, 8'd0);
        bus.in_valid = 4'b1010;
        bus.in_data1 = 4'd6;
        bus.in_data3 = 4'd9;
        #1;
        checkOutput("midrst_held_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_release_in_ready", int'(bus.in_ready), 4'b0010);
        @(posedge clk);
        #1;
        checkBeat("midrst_first", 1'b1, 4'd6, 2'd1, 8'd1);

        // Counter wrap after 256 accepts from a lone requester.
        doReset();
        applyStimulus(4'b0001, 4'd9, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 255; i++) @(posedge clk);
        #1;
        checkOutput("wrap_cnt255", int'(bus.xfer_cnt), 255);
        @(posedge clk);
        #1;
        checkBeat("wrap_cnt0", 1'b1, 4'd9, 2'd0, 8'd0);

        // Randomised run against a reference model and expectation queue.
        doReset();
        vld  = 4'b0000;
        mlg  = 2'd3;
        mov  = 1'b0;
        mcnt = 8'd0;
        for (int i = 0; i < 4; i++) pd[i] = 4'd0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            tail = (cyc >= 480);
            @(negedge clk);
            bus.in_valid  = vld;
            bus.in_data0  = pd[0];
            bus.in_data1  = pd[1];
            bus.in_data2  = pd[2];
            bus.in_data3  = pd[3];
            bus.out_ready = tail ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            sp  = !mov || bus.out_ready;
            fnd = 1'b0;
            win = mlg;
            for (int k = 1; k <= 4; k++) begin
                c = mlg + 2'(k);
                if (!fnd && vld[c]) begin
                    fnd = 1'b1;
                    win = c;
                end
            end
            acc = sp && fnd;
            checkOutput("rand_in_ready", int'(bus.in_ready), acc ? int'(4'b0001 << win) : 0);
            checkOutput("rand_out_valid", int'(bus.out_valid), int'(mov));
            if (mov && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rand_underflow actual=beat_held expected=no_beat");
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("rand_out_data", int'(bus.out_data), int'(b.data));
                    checkOutput("rand_out_src", int'(bus.out_src), int'(b.src));
                end
            end
            if (acc) begin
                b.src  = win;
                b.data = pd[win];
                exp_q.push_back(b);
            end
            @(posedge clk);
            if (acc) begin
                mlg  = win;
                mov  = 1'b1;
                mcnt = mcnt + 8'd1;
            end else if (bus.out_ready) begin
                mov = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (acc && (win == 2'(i))) begin
                    vld[i] = !tail && ($urandom_range(0, 1) == 1);
                    pd[i]  = 4'($urandom);
                end else if (!vld[i] && !tail && ($urandom_range(0, 2) == 0)) begin
                    vld[i] = 1'b1;
                    pd[i]  = 4'($urandom);
                end
            end
        end
        #1;
        checkOutput("rand_xfer_cnt", int'(bus.xfer_cnt), int'(mcnt));
        checkOutput("rand_queue_left", exp_q.size(), mov ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
